// File: rtl/fcl_loader_pkg.sv
// Shared types, default field geometry and preset row patterns for the
// field config loader.
package fcl_loader_pkg;

   localparam int DEF_FIELD_W = 32;
   localparam int DEF_FIELD_H = 32;

   typedef enum logic [1:0] {
      NO_REQ = 2'd0,
      CFG_1  = 2'd1,
      CFG_2  = 2'd2
   } load_cfg_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } fcl_state_t;

   // Glider in the top-left corner.
   function automatic logic [DEF_FIELD_W-1:0] cfg1_row(input int r);
      logic [DEF_FIELD_W-1:0] v;
      v = '0;
      case (r)
         0:       v[1]   = 1'b1;
         1:       v[2]   = 1'b1;
         2:       v[2:0] = 3'b111;
         default: v      = '0;
      endcase
      return v;
   endfunction

   // Horizontal blinker centred in the field.
   function automatic logic [DEF_FIELD_W-1:0] cfg2_row(input int r);
      logic [DEF_FIELD_W-1:0] v;
      v = '0;
      if (r == DEF_FIELD_H / 2) v[DEF_FIELD_W/2+1 -: 3] = 3'b111;
      return v;
   endfunction

endpackage

// File: rtl/fcl_loader_cfg_rom.sv
// Preset pattern ROM: both configurations stacked, addressed as {cfg_sel, row},
// with a registered read that holds its output while en_i is low.
module fcl_cfg_rom
   import fcl_loader_pkg::*;
#(
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int FIELD_H = DEF_FIELD_H,
   parameter int AW      = $clog2(FIELD_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [AW:0]        addr_i,
   output logic [FIELD_W-1:0] data_o
);

   logic [FIELD_W-1:0] rom_tbl [2*FIELD_H];
   logic [FIELD_W-1:0] data_q;

   // {cfg_sel, row} maps onto FIELD_H + row only for power-of-two heights.
   for (genvar gi = 0; gi < FIELD_H; gi++) begin : g_rows
      assign rom_tbl[gi]         = FIELD_W'(cfg1_row(gi));
      assign rom_tbl[FIELD_H+gi] = FIELD_W'(cfg2_row(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    data_q <= '0;
      else if (en_i) data_q <= rom_tbl[addr_i];
   end

   assign data_o = data_q;

endmodule

// File: rtl/fcl_loader.sv
// Field config loader: on a go pulse, streams the selected preset pattern one
// row per accepted write into the field memory.
module fcl_loader
   import fcl_loader_pkg::*;
#(
   parameter int FIELD_W = DEF_FIELD_W,
   parameter int FIELD_H = DEF_FIELD_H,
   parameter int AW      = $clog2(FIELD_H)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_go,
   input  load_cfg_req_t      i_cfg_req,
   output logic               o_is_loading,
   output logic               o_done,
   output logic               o_wr_en,
   input  logic               i_wr_ready,
   output logic [AW-1:0]      o_wr_addr,
   output logic [FIELD_W-1:0] o_wr_data
);

   fcl_state_t          state_q, state_d;
   logic                cfg_sel_q, cfg_sel_d;
   logic [AW-1:0]       wr_row_q, wr_row_d;
   logic [AW-1:0]       rd_row;
   logic                rom_en;
   logic [AW:0]         rom_addr;
   logic [FIELD_W-1:0]  rom_data;

   // The ROM always runs one row ahead of the row being presented.
   assign rd_row = wr_row_q + AW'(1);

   fcl_cfg_rom #(
      .FIELD_W (FIELD_W),
      .FIELD_H (FIELD_H),
      .AW      (AW)
   ) u_rom (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (rom_en),
      .addr_i (rom_addr),
      .data_o (rom_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cfg_sel_q <= 1'b0;
         wr_row_q  <= '0;
      end else begin
         state_q   <= state_d;
         cfg_sel_q <= cfg_sel_d;
         wr_row_q  <= wr_row_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cfg_sel_d    = cfg_sel_q;
      wr_row_d     = wr_row_q;
      rom_en       = 1'b0;
      rom_addr     = {cfg_sel_q, rd_row};
      o_is_loading = 1'b0;
      o_done       = 1'b0;
      o_wr_en      = 1'b0;
      o_wr_addr    = '0;
      o_wr_data    = '0;
      case (state_q)
         IDLE: begin
            if (i_go && (i_cfg_req == CFG_1 || i_cfg_req == CFG_2)) begin
               cfg_sel_d = (i_cfg_req == CFG_2);
               wr_row_d  = '0;
               state_d   = PRIME;
            end
         end
         PRIME: begin
            o_is_loading = 1'b1;
            rom_en       = 1'b1;
            rom_addr     = {cfg_sel_q, {AW{1'b0}}};
            state_d      = STREAM;
         end
         STREAM: begin
            o_is_loading = 1'b1;
            o_wr_en      = 1'b1;
            o_wr_addr    = wr_row_q;
            o_wr_data    = rom_data;
            // Last row: no further ROM read, so the row counter never wraps.
            if (i_wr_ready) begin
               if (wr_row_q == AW'(FIELD_H - 1)) begin
                  state_d = DONE;
               end else begin
                  rom_en   = 1'b1;
                  wr_row_d = rd_row;
               end
            end
         end
         DONE: begin
            o_is_loading = 1'b1;
            o_done       = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
